// File: rtl/pipeline_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_ctrl_if
// Description : Bundles the decode, execute, writeback and redirect signals
//               exchanged between the issue controller and the rest of the
//               core.
//               master = core side (drives decode/EX/WB/redirect inputs).
//               slave  = pipeline_ctrl (drives stall/issue/flush/status).
// Ports       : d_valid, d_pc, d_opcode, d_funct3, d_rd, d_rs1, d_rs2,
//               ex_busy, br_taken, br_target, wb_valid, wb_rd, resume
//               (master -> slave); stall, issue, flush, flush_pc, halted,
//               busy_map (slave -> master)
// Revision    : 1.0 - initial release
// ============================================================================
interface pipeline_ctrl_if;
  logic        d_valid;
  logic [31:0] d_pc;
  logic [6:0]  d_opcode;
  logic [2:0]  d_funct3;
  logic [4:0]  d_rd;
  logic [4:0]  d_rs1;
  logic [4:0]  d_rs2;
  logic        ex_busy;
  logic        br_taken;
  logic [31:0] br_target;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        resume;
  logic        stall;
  logic        issue;
  logic        flush;
  logic [31:0] flush_pc;
  logic        halted;
  logic [31:0] busy_map;

  modport master (
    output d_valid, d_pc, d_opcode, d_funct3, d_rd, d_rs1, d_rs2,
           ex_busy, br_taken, br_target, wb_valid, wb_rd, resume,
    input  stall, issue, flush, flush_pc, halted, busy_map
  );

  modport slave (
    input  d_valid, d_pc, d_opcode, d_funct3, d_rd, d_rs1, d_rs2,
           ex_busy, br_taken, br_target, wb_valid, wb_rd, resume,
    output stall, issue, flush, flush_pc, halted, busy_map
  );
endinterface
`default_nettype wire

// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_ctrl
// Description : Scoreboard-based issue controller for the RV32I core. Tracks
//               registers with pending writes, gates issue with STALL/ISSUE,
//               sequences redirect flushes and drains to HALT on ECALL/EBREAK.
// Ports       : clk, rst (sync, active-high)
//               bus (pipeline_ctrl_if.slave): decode fields, ex_busy,
//               br_taken/br_target, wb_valid/wb_rd, resume in;
//               stall, issue (comb), flush, flush_pc, halted, busy_map (reg)
// Parameters  : FLUSH_CYCLES - squash length after a redirect (1..15)
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_ctrl #(
  parameter int FLUSH_CYCLES = 2
) (
  input  wire             clk,
  input  wire             rst,
  pipeline_ctrl_if.slave  bus
);

  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd1;
  localparam logic [1:0] S_HALT  = 2'd2;
  localparam logic [1:0] S_FLUSH = 2'd3;

  localparam logic [3:0] C_FLUSH_LOAD = 4'(FLUSH_CYCLES);

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] busy_q, busy_d;
  logic [31:0] sys_pc_q, sys_pc_d;
  logic        flush_q, flush_d;
  logic [31:0] flush_pc_q, flush_pc_d;
  logic        halted_q, halted_d;

  logic        rs1_used, rs2_used, rd_wr, is_sys, hazard;
  logic        issue, stall;

  // Opcode classification
  always_comb begin
    rs1_used = 1'b0;
    rs2_used = 1'b0;
    rd_wr    = 1'b0;
    case (bus.d_opcode)
      7'b0110111, 7'b0010111, 7'b1101111: rd_wr = 1'b1;
      7'b1100111: begin rs1_used = 1'b1; rd_wr = 1'b1; end
      7'b1100011: begin rs1_used = 1'b1; rs2_used = 1'b1; end
      7'b0000011: begin rs1_used = 1'b1; rd_wr = 1'b1; end
      7'b0100011: begin rs1_used = 1'b1; rs2_used = 1'b1; end
      7'b0010011: begin rs1_used = 1'b1; rd_wr = 1'b1; end
      7'b0110011: begin rs1_used = 1'b1; rs2_used = 1'b1; rd_wr = 1'b1; end
      default: ;
    endcase
    is_sys = (bus.d_opcode == 7'b1110011) && (bus.d_funct3 == 3'd0);
  end

  // Registered map only: a writeback this cycle releases the reader next cycle.
  // The rd term blocks WAW so a single pending bit per register suffices.
  assign hazard = (rs1_used && (bus.d_rs1 != 5'd0) && busy_q[bus.d_rs1]) ||
                  (rs2_used && (bus.d_rs2 != 5'd0) && busy_q[bus.d_rs2]) ||
                  (rd_wr    && (bus.d_rd  != 5'd0) && busy_q[bus.d_rd]);

  // State register and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_RUN;
      cnt_q      <= 4'd0;
      busy_q     <= 32'd0;
      sys_pc_q   <= 32'd0;
      flush_q    <= 1'b0;
      flush_pc_q <= 32'd0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      sys_pc_q   <= sys_pc_d;
      flush_q    <= flush_d;
      flush_pc_q <= flush_pc_d;
      halted_q   <= halted_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sys_pc_d   = sys_pc_q;
    flush_d    = 1'b0;
    flush_pc_d = flush_pc_q;
    case (state_q)
      S_RUN, S_DRAIN: begin
        if (bus.br_taken) begin
          state_d    = S_FLUSH;
          cnt_d      = C_FLUSH_LOAD;
          flush_d    = 1'b1;
          flush_pc_d = bus.br_target;
        end else if (state_q == S_RUN) begin
          if (bus.d_valid && is_sys) begin
            state_d  = S_DRAIN;
            sys_pc_d = bus.d_pc;
          end
        end else if ((busy_q == 32'd0) && !bus.ex_busy) begin
          state_d = S_HALT;
        end
      end
      S_HALT: begin
        if (bus.resume) begin
          state_d    = S_FLUSH;
          cnt_d      = C_FLUSH_LOAD;
          flush_d    = 1'b1;
          flush_pc_d = sys_pc_q + 32'd4;
        end
      end
      S_FLUSH: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = S_RUN;
        end
      end
      default: state_d = S_RUN;
    endcase
    halted_d = (state_d == S_HALT);
  end

  // Scoreboard update: clear first so a same-cycle set wins
  always_comb begin
    busy_d = busy_q;
    if (bus.wb_valid) begin
      busy_d[bus.wb_rd] = 1'b0;
    end
    if (issue && rd_wr && (bus.d_rd != 5'd0)) begin
      busy_d[bus.d_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Output logic
  always_comb begin
    issue = 1'b0;
    stall = 1'b0;
    if (!rst) begin
      case (state_q)
        S_RUN: begin
          issue = bus.d_valid && !is_sys && !hazard && !bus.ex_busy && !bus.br_taken;
          stall = bus.d_valid && !issue && !bus.br_taken;
        end
        S_DRAIN, S_HALT: stall = 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.issue    = issue;
  assign bus.stall    = stall;
  assign bus.flush    = flush_q;
  assign bus.flush_pc = flush_pc_q;
  assign bus.halted   = halted_q;
  assign bus.busy_map = busy_q;

endmodule
`default_nettype wire
